// File: rtl/affine_processing_element.sv
// One column cell of a systolic Smith-Waterman array with affine (Gotoh) gaps.
// Define PE_MAX_TRACK_EN to enable running max_score/max_index tracking.
module affine_processing_element #(
  parameter int SCORE_WIDTH  = 8,
  parameter int LETTER_WIDTH = 2,
  parameter int SOURCE_WIDTH = 2,
  parameter int INDEX_WIDTH  = 10,
  parameter int MATCH        = 2,
  parameter int MISMATCH     = 1,
  parameter int GAP_OPEN     = 3,
  parameter int GAP_EXTEND   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [LETTER_WIDTH-1:0] load_letter,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic [LETTER_WIDTH-1:0] in_db_letter,
  input  logic [SCORE_WIDTH-1:0]  in_h_left,
  input  logic [SCORE_WIDTH-1:0]  in_e_left,
  output logic                    out_valid,
  output logic [LETTER_WIDTH-1:0] out_db_letter,
  output logic [SCORE_WIDTH-1:0]  out_h,
  output logic [SCORE_WIDTH-1:0]  out_e,
  output logic [SOURCE_WIDTH-1:0] out_source,
  output logic                    out_zero,
  output logic [SCORE_WIDTH-1:0]  max_score,
  output logic [INDEX_WIDTH-1:0]  max_index
);

  localparam logic [SCORE_WIDTH-1:0] MATCH_S      = SCORE_WIDTH'(MATCH);
  localparam logic [SCORE_WIDTH-1:0] MISMATCH_S   = SCORE_WIDTH'(MISMATCH);
  localparam logic [SCORE_WIDTH-1:0] GAP_OPEN_S   = SCORE_WIDTH'(GAP_OPEN);
  localparam logic [SCORE_WIDTH-1:0] GAP_EXTEND_S = SCORE_WIDTH'(GAP_EXTEND);

  typedef enum logic {UNLOADED, LOADED} state_t;

  state_t state, state_next;
  logic   accept;

  logic [LETTER_WIDTH-1:0] query;
  logic [SCORE_WIDTH-1:0]  h_self, f_self, h_left_d;
  logic [INDEX_WIDTH-1:0]  beat_idx, cur_idx;

  logic [SCORE_WIDTH-1:0]  diag, top, fp, e_val, f_val, d_val, h_val;
  logic [SOURCE_WIDTH-1:0] src_val;

  function automatic logic [SCORE_WIDTH-1:0] sat_sub(input logic [SCORE_WIDTH-1:0] a,
                                                     input logic [SCORE_WIDTH-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  function automatic logic [SCORE_WIDTH-1:0] sat_add(input logic [SCORE_WIDTH-1:0] a,
                                                     input logic [SCORE_WIDTH-1:0] b);
    logic [SCORE_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_WIDTH] ? '1 : s[SCORE_WIDTH-1:0];
  endfunction

  function automatic logic [SCORE_WIDTH-1:0] max2(input logic [SCORE_WIDTH-1:0] a,
                                                  input logic [SCORE_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNLOADED;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == UNLOADED && load_valid) state_next = LOADED;
  end

  always_comb begin
    accept = in_valid && (state == LOADED);
  end

  // Query updates regardless of state; a same-cycle beat still sees the old letter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             query <= '0;
    else if (load_valid) query <= load_letter;
  end

  always_comb begin
    diag  = in_first ? '0 : h_left_d;
    top   = in_first ? '0 : h_self;
    fp    = in_first ? '0 : f_self;
    e_val = max2(sat_sub(in_h_left, GAP_OPEN_S), sat_sub(in_e_left, GAP_EXTEND_S));
    f_val = max2(sat_sub(top, GAP_OPEN_S), sat_sub(fp, GAP_EXTEND_S));
    d_val = (in_db_letter == query) ? sat_add(diag, MATCH_S) : sat_sub(diag, MISMATCH_S);
    h_val = max2(d_val, max2(e_val, f_val));
    if (h_val == '0)        src_val = SOURCE_WIDTH'(0);
    else if (h_val == d_val) src_val = SOURCE_WIDTH'(1);
    else if (h_val == f_val) src_val = SOURCE_WIDTH'(2);
    else                     src_val = SOURCE_WIDTH'(3);
    cur_idx = in_first ? '0 : ((&beat_idx) ? beat_idx : beat_idx + 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_db_letter <= '0;
      out_h         <= '0;
      out_e         <= '0;
      out_source    <= '0;
      out_zero      <= 1'b0;
      h_self        <= '0;
      f_self        <= '0;
      h_left_d      <= '0;
      beat_idx      <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_db_letter <= in_db_letter;
        out_h         <= h_val;
        out_e         <= e_val;
        out_source    <= src_val;
        out_zero      <= (h_val == '0);
        h_self        <= h_val;
        f_self        <= f_val;
        h_left_d      <= in_h_left;
        beat_idx      <= cur_idx;
      end
    end
  end

`ifdef PE_MAX_TRACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_score <= '0;
      max_index <= '0;
    end else if (accept) begin
      if (in_first) begin
        max_score <= h_val;
        max_index <= '0;
      end else if (h_val > max_score) begin
        max_score <= h_val;
        max_index <= cur_idx;
      end
    end
  end
`else
  assign max_score = '0;
  assign max_index = '0;
`endif

endmodule

// File: tb/tb_affine_processing_element.sv
// Directed bench for affine_processing_element with an arithmetic reference model.
module tb_affine_processing_element;

  localparam int SW = 8;
  localparam int LW = 2;
  localparam int CW = 2;
  localparam int IW = 10;
  localparam int SMAX = 255;
  localparam int IMAX = 1023;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [LW-1:0] load_letter = '0;
  logic          in_valid = 1'b0;
  logic          in_first = 1'b0;
  logic [LW-1:0] in_db_letter = '0;
  logic [SW-1:0] in_h_left = '0;
  logic [SW-1:0] in_e_left = '0;
  logic          out_valid;
  logic [LW-1:0] out_db_letter;
  logic [SW-1:0] out_h;
  logic [SW-1:0] out_e;
  logic [CW-1:0] out_source;
  logic          out_zero;
  logic [SW-1:0] max_score;
  logic [IW-1:0] max_index;

  affine_processing_element #(
    .SCORE_WIDTH(SW), .LETTER_WIDTH(LW), .SOURCE_WIDTH(CW), .INDEX_WIDTH(IW),
    .MATCH(2), .MISMATCH(1), .GAP_OPEN(3), .GAP_EXTEND(1)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_letter(load_letter),
    .in_valid(in_valid), .in_first(in_first), .in_db_letter(in_db_letter),
    .in_h_left(in_h_left), .in_e_left(in_e_left),
    .out_valid(out_valid), .out_db_letter(out_db_letter), .out_h(out_h),
    .out_e(out_e), .out_source(out_source), .out_zero(out_zero),
    .max_score(max_score), .max_index(max_index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (values as of before the next active edge)
  int m_loaded, m_q, m_h, m_f, m_hld, m_idx, m_mx, m_mi;
  int exp_valid, exp_db, exp_h, exp_e, exp_src, exp_zero;

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic int ssub(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction
  function automatic int sadd(input int a, input int b);
    return (a + b > SMAX) ? SMAX : a + b;
  endfunction
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_loaded = 0; m_q = 0; m_h = 0; m_f = 0; m_hld = 0; m_idx = 0; m_mx = 0; m_mi = 0;
    exp_valid = 0; exp_db = 0; exp_h = 0; exp_e = 0; exp_src = 0; exp_zero = 0;
  endtask

  task automatic step(input bit ld, input int ll, input bit v, input bit f,
                      input int db, input int hl, input int el);
    int diag, top, fp, e, fv, d, h, idx;
    @(negedge clk);
    load_valid = ld; load_letter = LW'(ll); in_valid = v; in_first = f;
    in_db_letter = LW'(db); in_h_left = SW'(hl); in_e_left = SW'(el);
    exp_valid = (v && m_loaded != 0) ? 1 : 0;
    if (exp_valid != 0) begin
      diag = f ? 0 : m_hld;
      top  = f ? 0 : m_h;
      fp   = f ? 0 : m_f;
      e  = imax(ssub(hl, 3), ssub(el, 1));
      fv = imax(ssub(top, 3), ssub(fp, 1));
      d  = (db == m_q) ? sadd(diag, 2) : ssub(diag, 1);
      h  = imax(d, imax(e, fv));
      exp_src  = (h == 0) ? 0 : (h == d) ? 1 : (h == fv) ? 2 : 3;
      exp_h = h; exp_e = e; exp_db = db; exp_zero = (h == 0) ? 1 : 0;
      m_h = h; m_f = fv; m_hld = hl;
      idx = f ? 0 : ((m_idx + 1 > IMAX) ? IMAX : m_idx + 1);
      m_idx = idx;
      if (f) begin m_mx = h; m_mi = 0; end
      else if (h > m_mx) begin m_mx = h; m_mi = idx; end
    end
    if (ld) begin m_loaded = 1; m_q = ll; end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Single compare process: every cycle, just after the active edge
  always @(posedge clk) begin
    #1;
    chk("out_valid", int'(out_valid), exp_valid);
    chk("out_db_letter", int'(out_db_letter), exp_db);
    chk("out_h", int'(out_h), exp_h);
    chk("out_e", int'(out_e), exp_e);
    chk("out_source", int'(out_source), exp_src);
    chk("out_zero", int'(out_zero), exp_zero);
`ifdef PE_MAX_TRACK_EN
    chk("max_score", int'(max_score), m_mx);
    chk("max_index", int'(max_index), m_mi);
`else
    chk("max_score", int'(max_score), 0);
    chk("max_index", int'(max_index), 0);
`endif
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Beats before any load are dropped
    step(0, 0, 1, 1, 2, 0, 0);
    step(0, 0, 1, 0, 2, 7, 7);
    chk("m_drop_valid", exp_valid, 0);
    idle();

    step(1, 2, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 2, 0, 0);
    chk("m_first_h", exp_h, 2);
    chk("m_first_src", exp_src, 1);
    step(0, 0, 1, 0, 2, 9, 0);
    chk("m_left_h", exp_h, 6);
    chk("m_left_src", exp_src, 3);
    chk("m_left_idx", m_mi, 1);
    step(0, 0, 1, 1, 1, 0, 0);
    chk("m_zero_h", exp_h, 0);
    chk("m_zero_flag", exp_zero, 1);
    idle();
    idle();

    // Saturating diagonal
    step(0, 0, 1, 0, 3, 254, 0);
    chk("m_e251", exp_h, 251);
    step(0, 0, 1, 0, 2, 0, 0);
    chk("m_sat_h", exp_h, 255);
    chk("m_sat_src", exp_src, 1);

    // Same-cycle load while loaded: beat scored with old letter 2
    step(1, 1, 1, 0, 1, 0, 0);
    chk("m_oldq_h", exp_h, 252);
    chk("m_oldq_src", exp_src, 2);
    step(0, 0, 1, 1, 1, 0, 0);
    chk("m_newq_h", exp_h, 2);
    step(0, 0, 1, 1, 1, 5, 0);
    chk("m_tie_src", exp_src, 1);

    // Long run to drive the beat index into saturation
    for (int i = 0; i < 1030; i++)
      step(0, 0, 1, 0, i % 4, (i * 37) % 256, (i * 11) % 256);
    chk("m_idx_sat", m_idx, IMAX);
    idle();

    // Mid-stream reset: outputs clear immediately
    step(0, 0, 1, 0, 1, 200, 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; load_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_out_h", int'(out_h), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_e", int'(out_e), 0);
    chk("rst_out_source", int'(out_source), 0);
    @(negedge clk);
    rst = 1'b0;

    step(0, 0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1, 0, 0);
    chk("m_unl_same_drop", exp_valid, 0);
    step(0, 0, 1, 1, 1, 4, 8);
    chk("m_after_rst_h", exp_h, 7);
    chk("m_after_rst_src", exp_src, 3);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/affine_processing_element.md
Name: affine_processing_element

Overview:
- Registered, parametrised successor to the single-cell linear-gap PE.
- One column cell of the systolic Smith-Waterman array: holds one query letter and computes one H cell per accepted database beat.
- Uses affine gaps (Gotoh E/F) with saturating unsigned arithmetic.
- Forwards H, E and the database letter to the next PE with 1-cycle latency.

Parameters:
- SCORE_WIDTH, 8: width of all score signals.
- LETTER_WIDTH, 2: width of query and database letters.
- SOURCE_WIDTH, 2: width of the traceback source code.
- INDEX_WIDTH, 10: width of the beat index counter.
- MATCH, 2: added to the diagonal on a letter match.
- MISMATCH, 1: subtracted from the diagonal on a mismatch.
- GAP_OPEN, 3: penalty to open a gap.
- GAP_EXTEND, 1: penalty to extend a gap.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  load a new query letter.
- load_letter  in  LETTER_WIDTH  query letter to load.
- in_valid  in  1  database beat valid.
- in_first  in  1  beat is row 0 of a new database sequence.
- in_db_letter  in  LETTER_WIDTH  database letter.
- in_h_left  in  SCORE_WIDTH  H from the previous PE, same row.
- in_e_left  in  SCORE_WIDTH  E from the previous PE, same row.
- out_valid  out  1  registered beat valid.
- out_db_letter  out  LETTER_WIDTH  forwarded database letter.
- out_h  out  SCORE_WIDTH  cell score H.
- out_e  out  SCORE_WIDTH  cell horizontal-gap score E.
- out_source  out  SOURCE_WIDTH  traceback code.
- out_zero  out  1  high when out_h == 0.
- max_score  out  SCORE_WIDTH  running maximum H (optional feature).
- max_index  out  INDEX_WIDTH  beat index of max_score (optional feature).

Behaviour:
- Reset: all outputs 0; FSM in UNLOADED; internal h_self, f_self, h_left_d, query register, beat counter all 0.
- FSM has two states:
  - UNLOADED -> LOADED on load_valid; query register <= load_letter.
  - LOADED stays LOADED. A further load_valid overwrites the query letter.
  - There is no return to UNLOADED except via rst.
- Beat acceptance: a beat is accepted only when in_valid is high and state is LOADED. In_valid in UNLOADED is dropped, with out_valid = 0.
- load_valid and in_valid in the same cycle while LOADED: the beat uses the old letter; the new letter is effective from the next cycle. In UNLOADED the same-cycle beat is dropped.
- Per accepted beat (sat_sub floors at 0, sat_add clamps at 2^SCORE_WIDTH-1):
  - diag = in_first ? 0 : h_left_d; top = in_first ? 0 : h_self; fp = in_first ? 0 : f_self.
  - E = max(sat_sub(in_h_left, GAP_OPEN), sat_sub(in_e_left, GAP_EXTEND)).
  - F = max(sat_sub(top, GAP_OPEN), sat_sub(fp, GAP_EXTEND)).
  - D = (in_db_letter == query) ? sat_add(diag, MATCH) : sat_sub(diag, MISMATCH).
  - H = max(D, E, F), floored at 0 implicitly.
- Source encoding:
  - 00 when H == 0, overriding all other codes.
  - Otherwise 01 diag, 10 top (F), 11 left (E).
  - Tie priority: diag > top > left.
- Registers updated on each accepted beat: out_h <= H; out_e <= E; out_source; out_zero <= (H == 0); out_db_letter <= in_db_letter; h_self <= H; f_self <= F; h_left_d <= in_h_left.
- Latency and hold:
  - Latency is exactly 1 cycle; out_valid <= accepted beat.
  - On a non-accepted cycle out_valid <= 0 and all data outputs and internal state hold.
- Beat index: 0 on an in_first beat, else previous + 1; saturates at all-ones.
- Reset mid-stream: immediate return to reset values; the first beat after reset requires a load first.

Optional Feature:
- Macro: PE_MAX_TRACK_EN.
- Defined:
  - On an accepted beat, if in_first, max_score <= H and max_index <= 0.
  - Otherwise, if H > max_score (strict, so earliest index wins a tie), max_score <= H and max_index <= the current beat index.
- Undefined: max_score and max_index are tied to 0, and no max registers are synthesised.

Test Plan:
- Reset, then in_valid=1 with no load -> out_valid stays 0; all outputs 0.
- Load 2; beat first, db=2, h_left=0, e_left=0 -> next cycle out_h=2, source=01, out_e=0, out_zero=0.
- Continuing, beat db=2, h_left=9, e_left=0 -> D=2, E=6, F=0; out_h=6, source=11, out_e=6. With PE_MAX_TRACK_EN: max_score=6, max_index=1.
- First beat db=1 vs query 2, inputs 0 -> out_h=0, out_zero=1, source=00.
- Saturation: beat h_left=254, then a matching beat with in_h_left=0 -> diag 254+2 clamps, out_h=255.
- Same-cycle load 1 + beat db=1 with query 2 -> mismatch scored. The next beat db=1 matches. Asserting rst mid-stream -> outputs 0 the same cycle.
